// File: rtl/pattern_rec_pkg.sv
// ---------------------------------------------------------------------------
// pattern_rec_pkg
//
// Shared definitions for the LED pattern recorder: the FSM state codes, the
// LED data width, the default address width, and a small helper that tells
// whether a state runs the step divider.
//
// State code 2'd3 is unused. The FSM treats it as illegal and recovers to
// IDLE.
// ---------------------------------------------------------------------------
package pattern_rec_pkg;

    localparam int LED_W     = 8;
    localparam int DEF_ADR_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    // The divider only runs while stepping through the pattern memory.
    function automatic logic step_active(input logic [1:0] st);
        return (st == ST_RECORD) || (st == ST_PLAY);
    endfunction

endpackage

// File: rtl/pattern_recorder_ram_8d.sv
// ---------------------------------------------------------------------------
// ram_8d
//
// Single-port synchronous RAM, 2**ADR_W words x LED_W bits. The read output
// is registered: q shows mem[addr] from the clock edge after the address is
// presented. On a write cycle, q returns the old contents (read-first).
// The contents have no reset.
//
// Ports
//   clk   in   clock, rising edge
//   we    in   write enable
//   addr  in   word address
//   d     in   write data
//   q     out  registered read data
// ---------------------------------------------------------------------------
module ram_8d
    import pattern_rec_pkg::*;
#(
    parameter int ADR_W = DEF_ADR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADR_W-1:0] addr,
    input  logic [LED_W-1:0] d,
    output logic [LED_W-1:0] q
);

    logic [LED_W-1:0] mem [2**ADR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/pattern_recorder.sv
// ---------------------------------------------------------------------------
// pattern_recorder
//
// Records a 2**ADR_W-step LED pattern from the switches into RAM. Recording
// advances one step every DIV_BY clock cycles. After the last step, the block
// plays the pattern back on the LEDs in an endless loop at the same step rate.
//
// Parameters
//   DIV_BY  clock cycles per step (2 or more)
//   ADR_W   address width; the pattern has 2**ADR_W steps
//
// Ports
//   CLK    in   system clock, rising edge
//   RESET  in   asynchronous reset, active low
//   SW     in   switch sample; written to RAM on each record step
//   START  in   one-cycle pulse that starts a new recording
//   LED    out  last recorded sample (RECORD) or played-back sample (PLAY)
//   BUSY   out  high while recording
//   DONE   out  one-cycle pulse after the final sample is written
//   ADR    out  current step address, for debug display
// ---------------------------------------------------------------------------
module pattern_recorder
    import pattern_rec_pkg::*;
#(
    parameter int DIV_BY = 25,
    parameter int ADR_W  = DEF_ADR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [LED_W-1:0] SW,
    input  logic             START,
    output logic [LED_W-1:0] LED,
    output logic             BUSY,
    output logic             DONE,
    output logic [ADR_W-1:0] ADR
);

    localparam int               DIV_W    = (DIV_BY > 2) ? $clog2(DIV_BY) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_BY - 1);
    localparam logic [ADR_W-1:0] ADR_LAST = '1;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [ADR_W-1:0] adr;
    logic [LED_W-1:0] led_q;
    logic             done_q;

    logic             tick;
    logic             rec_tick;
    logic             play_tick;
    logic             ram_we;

    // Read-data pipeline: ram_q_p1 holds mem[adr] one cycle after a play tick.
    // vld_p1 marks that this read must reach the LEDs.
    logic [LED_W-1:0] ram_q_p1;
    logic             vld_p1;

    always_comb begin
        tick      = step_active(state) && (div_cnt == DIV_LAST);
        rec_tick  = (state == ST_RECORD) && tick;
        // START in PLAY overrides a coincident tick, so that read is dropped.
        play_tick = (state == ST_PLAY) && tick && !START;
        ram_we    = rec_tick;
    end

    ram_8d #(
        .ADR_W (ADR_W)
    ) u_ram (
        .clk  (CLK),
        .we   (ram_we),
        .addr (adr),
        .d    (SW),
        .q    (ram_q_p1)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            adr     <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            vld_p1 <= play_tick;

            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    adr     <= '0;
                    if (START) begin
                        state <= ST_RECORD;
                    end
                end

                // START is ignored while recording.
                ST_RECORD: begin
                    if (tick) begin
                        div_cnt <= '0;
                        led_q   <= SW;
                        if (adr == ADR_LAST) begin
                            adr    <= '0;
                            done_q <= 1'b1;
                            state  <= ST_PLAY;
                        end else begin
                            adr <= adr + ADR_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                ST_PLAY: begin
                    if (START) begin
                        // LEDs keep the last played value until the first
                        // record tick. A read still in flight is dropped.
                        state   <= ST_RECORD;
                        adr     <= '0;
                        div_cnt <= '0;
                    end else begin
                        if (vld_p1) begin
                            led_q <= ram_q_p1;
                        end
                        if (tick) begin
                            div_cnt <= '0;
                            adr     <= adr + ADR_W'(1);
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    div_cnt <= '0;
                    adr     <= '0;
                end
            endcase
        end
    end

    assign LED  = led_q;
    assign BUSY = (state == ST_RECORD);
    assign DONE = done_q;
    assign ADR  = adr;

endmodule

// File: tb/tb_pattern_recorder.sv
// ---------------------------------------------------------------------------
// tb_pattern_recorder
//
// Directed bench for pattern_recorder with DIV_BY=4.
//
// Cycle n is the clock period that ends at the n-th rising edge after START
// is applied, with the START cycle numbered 0. Inputs are driven during
// cycle n. Outputs are sampled 1 ns after the edge that ends cycle n, so the
// sample shows the values of cycle n+1.
//
// Record ticks fall in cycles 4+4k. After the final record tick, play ticks
// fall in cycles 132+4j.
// ---------------------------------------------------------------------------
module tb_pattern_recorder;

    localparam int DIV_BY = 4;
    localparam int ADR_W  = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] SW = 8'h00;
    logic       START = 1'b0;
    logic [7:0] LED;
    logic       BUSY;
    logic       DONE;
    logic [4:0] ADR;

    int n_vec = 0;
    int n_bad = 0;

    pattern_recorder #(
        .DIV_BY (DIV_BY),
        .ADR_W  (ADR_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SW    (SW),
        .START (START),
        .LED   (LED),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ADR   (ADR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       start;
        logic [7:0] sw;
        logic [7:0] led;
        logic [4:0] adr;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [10];

    // One-hot walking pattern used for record step k.
    function automatic logic [7:0] pat(input int k);
        logic [7:0] one;
        one = 8'h01;
        return one << (k % 8);
    endfunction

    task automatic check(input string name, input logic [7:0] led_e,
                         input logic [4:0] adr_e, input logic busy_e,
                         input logic done_e);
        n_vec++;
        if (LED !== led_e || ADR !== adr_e || BUSY !== busy_e || DONE !== done_e) begin
            n_bad++;
            $display("FAIL %s: got LED=%h ADR=%0d BUSY=%b DONE=%b, want LED=%h ADR=%0d BUSY=%b DONE=%b",
                     name, LED, ADR, BUSY, DONE, led_e, adr_e, busy_e, done_e);
        end
    endtask

    // Drive inputs for one cycle, then sample just after the next rising edge.
    task automatic run_cycle(input logic st, input logic [7:0] sw);
        START = st;
        SW    = sw;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] led_e;
        logic [4:0] adr_e;
        int         c;

        // Table rows, in order: start, sw, then the expected led, adr, busy and
        // done for the following cycle.
        tbl[0] = '{1'b1, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h01, 8'h01, 5'd1, 1'b1, 1'b0};  // first tick, cycle 4
        tbl[5] = '{1'b0, 8'hAA, 8'h01, 5'd1, 1'b1, 1'b0};  // SW ignored between ticks
        tbl[6] = '{1'b0, 8'hAA, 8'h01, 5'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'hAA, 8'h01, 5'd1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h02, 8'h02, 5'd2, 1'b1, 1'b0};  // second tick
        tbl[9] = '{1'b1, 8'hFF, 8'h02, 5'd2, 1'b1, 1'b0};  // START ignored in RECORD

        // Reset state, released away from a clock edge.
        #22;
        check("reset_hold", 8'h00, 5'd0, 1'b0, 1'b0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 8'hFF);
            check($sformatf("idle_%0d", i), 8'h00, 5'd0, 1'b0, 1'b0);
        end

        // Table-driven start of the first recording, cycles 0..9.
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].start, tbl[i].sw);
            check($sformatf("tbl_%0d", i), tbl[i].led, tbl[i].adr, tbl[i].busy, tbl[i].done);
        end

        // Rest of the walking-one recording. START falls on step 10's tick (cycle 44).
        for (int n = 10; n <= 128; n++) begin
            run_cycle(n == 44, pat((n >> 2) - 1));
            adr_e = 5'(((n - 4) / 4 + 1) % 32);
            check($sformatf("rec_c%0d", n + 1), pat((n - 4) / 4), adr_e, n <= 127, n == 128);
        end

        // Playback, more than 70 steps, covering several address wraps.
        for (int n = 129; n <= 419; n++) begin
            run_cycle(1'b0, 8'h55);
            c     = n + 1;
            led_e = (c >= 134) ? pat((c - 134) / 4) : 8'h80;
            adr_e = (c >= 133) ? 5'(((c - 133) / 4 + 1) % 32) : 5'd0;
            check($sformatf("play_c%0d", c), led_e, adr_e, 1'b0, 1'b0);
        end

        // START on a play tick (cycle 420). LED holds 80 until the first record tick.
        run_cycle(1'b1, 8'h55);
        check("restart_c421", 8'h80, 5'd0, 1'b1, 1'b0);
        for (int n = 421; n <= 423; n++) begin
            run_cycle(1'b0, 8'hA5);
            check($sformatf("restart_hold_c%0d", n + 1), 8'h80, 5'd0, 1'b1, 1'b0);
        end

        // Record A5 for 12 steps (ticks at 424..468).
        for (int n = 424; n <= 469; n++) begin
            run_cycle(1'b0, 8'hA5);
            check($sformatf("rec_a5_c%0d", n + 1), 8'hA5, 5'((n - 424) / 4 + 1), 1'b1, 1'b0);
        end

        // Asynchronous reset asserted mid-cycle while recording.
        #3;
        RESET = 1'b0;
        #1;
        check("async_reset", 8'h00, 5'd0, 1'b0, 1'b0);
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 8'h3C);
            check($sformatf("post_reset_idle_%0d", i), 8'h00, 5'd0, 1'b0, 1'b0);
        end

        // New full recording of 3C.
        run_cycle(1'b1, 8'h3C);
        check("rec3c_start", 8'h00, 5'd0, 1'b1, 1'b0);
        for (int n = 1; n <= 128; n++) begin
            run_cycle(1'b0, 8'h3C);
            led_e = (n >= 4) ? 8'h3C : 8'h00;
            adr_e = (n >= 4) ? 5'(((n - 4) / 4 + 1) % 32) : 5'd0;
            check($sformatf("rec3c_c%0d", n + 1), led_e, adr_e, n <= 127, n == 128);
        end

        // Playback must show 3C at every step; the old A5 data must not appear.
        for (int n = 129; n <= 129 + 4 * 34; n++) begin
            run_cycle(1'b0, 8'h00);
            c     = n + 1;
            adr_e = (c >= 133) ? 5'(((c - 133) / 4 + 1) % 32) : 5'd0;
            check($sformatf("play3c_c%0d", c), 8'h3C, adr_e, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
